// File: rtl/afifo_rd_if.sv
// Read-side bundle between the FIFO pointer/RAM logic, the read port and the downstream sink.
// master is the read port itself; slave is the environment around it.
interface afifo_rd_if #(
    parameter int unsigned DSIZE = 8
);
    logic             empty;
    logic             ren;
    logic [DSIZE-1:0] rdata;
    logic [DSIZE-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [1:0]       dout_cnt;

    modport master (
        input  empty,
        input  rdata,
        input  dout_ready,
        output ren,
        output dout,
        output dout_valid,
        output dout_cnt
    );

    modport slave (
        output empty,
        output rdata,
        output dout_ready,
        input  ren,
        input  dout,
        input  dout_valid,
        input  dout_cnt
    );
endinterface

// File: rtl/afifo_rd_port.sv
// Async FIFO read-domain consumer: issues reads against a 1-cycle-latency RAM and presents
// a first-word-fall-through stream through a 2-entry output buffer.
module afifo_rd_port #(
    parameter int unsigned DSIZE = 8
) (
    input logic        rclk,
    input logic        rrst_n,
    afifo_rd_if.master bus
);
    logic [DSIZE-1:0] buf0_q, buf0_d;
    logic [DSIZE-1:0] buf1_q, buf1_d;
    logic [1:0]       occ_q, occ_d;
    logic             infl_q;

    logic       pop;
    logic [2:0] level;
    logic [1:0] occ_eff;

    assign pop = bus.dout_valid & bus.dout_ready;

    // Occupancy after this cycle's arrival and pop; pop implies occ_q >= 1, so no underflow.
    assign level   = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    assign occ_eff = occ_q - {1'b0, pop};

    // Only read when the returning word is guaranteed a slot.
    assign bus.ren = ~bus.empty & (level < 3'd2);

    assign bus.dout       = buf0_q;
    assign bus.dout_valid = (occ_q != 2'd0);
    assign bus.dout_cnt   = occ_q;

    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = level[1:0];
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (infl_q) begin
            case (occ_eff)
                2'd0:    buf0_d = bus.rdata;
                2'd1:    buf1_d = bus.rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            buf0_q <= '0;
            buf1_q <= '0;
            occ_q  <= 2'd0;
            infl_q <= 1'b0;
        end else begin
            buf0_q <= buf0_d;
            buf1_q <= buf1_d;
            occ_q  <= occ_d;
            infl_q <= bus.ren;
        end
    end
endmodule
